mrc_digit_align_check: RTL and testbench

Downstream companion of the 8-digit mixed-radix conversion (MRC) pipeline. The MRC produces mixed-radix digit k exactly k·STAGE_LAT cycles after digit 0 enters. This block deskews the eight digit streams into one aligned word and tracks valid. It classifies each word from its two redundant top digits as positive, negative (complement form) or erroneous, and keeps a saturating error count for the error-correcting-arithmetic monitor.

---
 rtl/mrc_digit_align_check.sv | 154 +++++++++++++++
 tb/tb_mrc_digit_align_check.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mrc_digit_align_check.sv
// Deskews the eight MRC digit streams into one aligned word, classifies the
// word from its two redundant top digits and keeps a saturating error count.
module mrc_digit_align_check #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned STAGE_LAT  = 3,
    parameter int unsigned MOD6       = 262051,
    parameter int unsigned MOD7       = 262069,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   dig_in_0,
    input  logic [DATA_WIDTH-1:0]   dig_in_1,
    input  logic [DATA_WIDTH-1:0]   dig_in_2,
    input  logic [DATA_WIDTH-1:0]   dig_in_3,
    input  logic [DATA_WIDTH-1:0]   dig_in_4,
    input  logic [DATA_WIDTH-1:0]   dig_in_5,
    input  logic [DATA_WIDTH-1:0]   dig_in_6,
    input  logic [DATA_WIDTH-1:0]   dig_in_7,
    input  logic                    cnt_clr,
    output logic                    out_valid,
    output logic [8*DATA_WIDTH-1:0] out_digits,
    output logic                    out_neg,
    output logic                    out_err,
    output logic [CNT_W-1:0]        err_count
);

    localparam int unsigned ValidDepth = 7 * STAGE_LAT;

    localparam logic [DATA_WIDTH-1:0] Mod6Val = DATA_WIDTH'(MOD6);
    localparam logic [DATA_WIDTH-1:0] Mod7Val = DATA_WIDTH'(MOD7);
    localparam logic [DATA_WIDTH-1:0] Mod6Neg = DATA_WIDTH'(MOD6 - 1);
    localparam logic [DATA_WIDTH-1:0] Mod7Neg = DATA_WIDTH'(MOD7 - 1);

    // Zero-length delay lines cannot be built; reject at elaboration.
    if (STAGE_LAT == 0) begin : g_stage_lat_check
        $error("mrc_digit_align_check: STAGE_LAT must be at least 1");
    end

    logic [DATA_WIDTH-1:0] dig_in  [8];
    logic [DATA_WIDTH-1:0] aligned [8];

    assign dig_in[0] = dig_in_0;
    assign dig_in[1] = dig_in_1;
    assign dig_in[2] = dig_in_2;
    assign dig_in[3] = dig_in_3;
    assign dig_in[4] = dig_in_4;
    assign dig_in[5] = dig_in_5;
    assign dig_in[6] = dig_in_6;
    assign dig_in[7] = dig_in_7;

    // Digit 7 arrives last, so it sets the alignment point and is not delayed.
    assign aligned[7] = dig_in[7];

    for (genvar k = 0; k < 7; k++) begin : g_dly
        localparam int unsigned Depth = (7 - k) * STAGE_LAT;

        logic [DATA_WIDTH-1:0] pipe_q [Depth];

        // Free-running shift register; shifts every cycle regardless of valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= dig_in[k];
                for (int unsigned i = 1; i < Depth; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign aligned[k] = pipe_q[Depth-1];
    end

    logic [ValidDepth-1:0] vld_q;
    logic                  vld_aligned;

    // Valid delay line matching digit 0's skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[ValidDepth-2:0], in_valid};
        end
    end

    assign vld_aligned = vld_q[ValidDepth-1];

    logic                    is_pos;
    logic                    is_neg;
    logic                    is_err;
    logic [8*DATA_WIDTH-1:0] digits_d;
    logic                    neg_d;
    logic                    err_d;

    // Classify the aligned word from its redundant digits and pack the digits.
    always_comb begin
        is_pos = (aligned[6] == '0) && (aligned[7] == '0);
        is_neg = (aligned[6] == Mod6Neg) && (aligned[7] == Mod7Neg);
        // Range checks catch upsets pushing a redundant digit past its modulus.
        is_err = !(is_pos || is_neg) || (aligned[6] >= Mod6Val) || (aligned[7] >= Mod7Val);
        neg_d  = vld_aligned && is_neg && !is_err;
        err_d  = vld_aligned && is_err;
        digits_d = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            digits_d[k*DATA_WIDTH +: DATA_WIDTH] = aligned[k];
        end
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats increment; increment holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    logic                    valid_q;
    logic [8*DATA_WIDTH-1:0] digits_q;
    logic                    neg_q;
    logic                    err_q;

    // Output register and error counter, loaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            digits_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= vld_aligned;
            digits_q <= digits_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_digits = digits_q;
    assign out_neg    = neg_q;
    assign out_err    = err_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_mrc_digit_align_check.sv
// Table-driven bench: words are placed on a slot timeline with their digits
// skewed by k*STAGE_LAT; outputs are checked LAT slots after each word.
module tb_mrc_digit_align_check;

    localparam int unsigned DW    = 18;
    localparam int unsigned SL    = 3;
    localparam int          LAT   = 7 * SL + 1;
    localparam int          NSLOT = 180;
    localparam int          RSLOT = 130;
    localparam int unsigned M6    = 262051;
    localparam int unsigned M7    = 262069;

    typedef struct {
        int                  slot;
        bit                  valid;
        logic [7:0][DW-1:0]  d;
        bit                  neg;
        bit                  err;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [DW-1:0]   dig_in_0, dig_in_1, dig_in_2, dig_in_3;
    logic [DW-1:0]   dig_in_4, dig_in_5, dig_in_6, dig_in_7;
    logic            cnt_clr;
    logic            out_valid, out_neg, out_err;
    logic [8*DW-1:0] out_digits;
    logic [15:0]     err_count;
    logic            out_valid4, out_neg4, out_err4;
    logic [8*DW-1:0] out_digits4;
    logic [3:0]      err_count4;

    always #5 clk = ~clk;

    mrc_digit_align_check #(.DATA_WIDTH(DW), .STAGE_LAT(SL), .MOD6(M6), .MOD7(M7), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .dig_in_0(dig_in_0), .dig_in_1(dig_in_1), .dig_in_2(dig_in_2), .dig_in_3(dig_in_3),
        .dig_in_4(dig_in_4), .dig_in_5(dig_in_5), .dig_in_6(dig_in_6), .dig_in_7(dig_in_7),
        .cnt_clr(cnt_clr), .out_valid(out_valid), .out_digits(out_digits),
        .out_neg(out_neg), .out_err(out_err), .err_count(err_count)
    );

    mrc_digit_align_check #(.DATA_WIDTH(DW), .STAGE_LAT(SL), .MOD6(M6), .MOD7(M7), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .dig_in_0(dig_in_0), .dig_in_1(dig_in_1), .dig_in_2(dig_in_2), .dig_in_3(dig_in_3),
        .dig_in_4(dig_in_4), .dig_in_5(dig_in_5), .dig_in_6(dig_in_6), .dig_in_7(dig_in_7),
        .cnt_clr(cnt_clr), .out_valid(out_valid4), .out_digits(out_digits4),
        .out_neg(out_neg4), .out_err(out_err4), .err_count(err_count4)
    );

    int n_checks = 0;
    int n_errors = 0;

    vec_t               vecs[$];
    bit                 sv   [NSLOT];
    bit                 sclr [NSLOT];
    logic [7:0][DW-1:0] sd   [NSLOT];
    bit                 ev   [NSLOT];
    bit                 en   [NSLOT];
    bit                 ee   [NSLOT];
    logic [7:0][DW-1:0] ed   [NSLOT];
    int                 cnt_m;
    int                 cnt4_m;

    task automatic chk(input string name, input int m, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s slot %0d: got %0d, expected %0d", name, m, got, exp);
        end
    endtask

    function automatic vec_t mk(input int slot, input bit v,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                                input logic [DW-1:0] d4, input logic [DW-1:0] d5,
                                input logic [DW-1:0] d6, input logic [DW-1:0] d7,
                                input bit neg, input bit err);
        vec_t r;
        r.slot  = slot;
        r.valid = v;
        r.d     = {d7, d6, d5, d4, d3, d2, d1, d0};
        r.neg   = neg;
        r.err   = err;
        return r;
    endfunction

    task automatic apply(input int m);
        in_valid = sv[m];
        cnt_clr  = sclr[m];
        dig_in_0 = sd[m][0];
        dig_in_1 = sd[m][1];
        dig_in_2 = sd[m][2];
        dig_in_3 = sd[m][3];
        dig_in_4 = sd[m][4];
        dig_in_5 = sd[m][5];
        dig_in_6 = sd[m][6];
        dig_in_7 = sd[m][7];
    endtask

    task automatic check_slot(input int m);
        if (m == RSLOT + 1) begin
            cnt_m  = 0;
            cnt4_m = 0;
        end else if (m > 0 && sclr[m-1]) begin
            cnt_m  = 0;
            cnt4_m = 0;
        end else if (ee[m]) begin
            cnt_m  = (cnt_m  < 65535) ? cnt_m  + 1 : cnt_m;
            cnt4_m = (cnt4_m < 15)    ? cnt4_m + 1 : cnt4_m;
        end
        chk("out_valid", m, 32'(out_valid), 32'(ev[m]));
        chk("out_neg", m, 32'(out_neg), 32'(en[m]));
        chk("out_err", m, 32'(out_err), 32'(ee[m]));
        chk("out_err_w4", m, 32'(out_err4), 32'(ee[m]));
        chk("err_count", m, 32'(err_count), 32'(cnt_m));
        chk("err_count_w4", m, 32'(err_count4), 32'(cnt4_m));
        if (ev[m]) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("digit%0d", k), m, 32'(out_digits[k*DW +: DW]), 32'(ed[m][k]));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < NSLOT; m++) begin
            sv[m] = 1'b0; sclr[m] = 1'b0; sd[m] = '0;
            ev[m] = 1'b0; en[m] = 1'b0; ee[m] = 1'b0; ed[m] = '0;
        end
        apply(0);

        // Vector table: positive, negative, error, out-of-range, invalid.
        vecs.push_back(mk(0, 1, 5, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2, 1, 3, 2, 7, 9, 11, 13, 18'(M6 - 1), 18'(M7 - 1), 1, 0));
        vecs.push_back(mk(4, 1, 4, 0, 0, 0, 0, 0, 7, 0, 0, 1));
        vecs.push_back(mk(6, 1, 6, 0, 0, 0, 0, 0, 0, 18'(M7), 0, 1));
        vecs.push_back(mk(8, 0, 8, 0, 0, 0, 0, 0, 0, 18'(M7), 0, 0));
        // Back-to-back stream, alternating positive/negative.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(30 + i, 1, 18'(i), 18'(100 + i), 18'(200 + i), 18'(300 + i),
                              18'(400 + i), 18'(500 + i),
                              (i % 2 == 1) ? 18'(M6 - 1) : 18'(0),
                              (i % 2 == 1) ? 18'(M7 - 1) : 18'(0),
                              (i % 2 == 1), 0));
        end
        // Error burst: saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            vecs.push_back(mk(50 + i, 1, 18'(i), 0, 0, 0, 0, 0, 1, 2, 0, 1));
        end
        // Error word registering together with cnt_clr, then one more error.
        vecs.push_back(mk(80, 1, 1, 0, 0, 0, 0, 0, 9, 9, 0, 1));
        vecs.push_back(mk(81, 1, 2, 0, 0, 0, 0, 0, 18'(M6 - 1), 0, 0, 1));
        sclr[80 + LAT - 1] = 1'b1;
        // Words in flight at the reset pulse; never qualified.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(120 + i, 1, 18'(i), 0, 0, 0, 0, 0, 5, 5, 0, 1));
        end
        // First word after reset.
        vecs.push_back(mk(140, 1, 7, 1, 2, 3, 4, 5, 18'(M6 - 1), 18'(M7 - 1), 1, 0));

        foreach (vecs[j]) begin
            sv[vecs[j].slot] = vecs[j].valid;
            for (int k = 0; k < 8; k++) begin
                sd[vecs[j].slot + k * SL][k] = vecs[j].d[k];
            end
            if (vecs[j].slot + LAT < NSLOT) begin
                ev[vecs[j].slot + LAT] = vecs[j].valid;
                en[vecs[j].slot + LAT] = vecs[j].valid && vecs[j].neg;
                ee[vecs[j].slot + LAT] = vecs[j].valid && vecs[j].err;
                ed[vecs[j].slot + LAT] = vecs[j].d;
            end
        end
        for (int m = RSLOT + 1; m <= RSLOT + LAT; m++) begin
            ev[m] = 1'b0; en[m] = 1'b0; ee[m] = 1'b0;
        end
        cnt_m  = 0;
        cnt4_m = 0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int m = 0; m < NSLOT; m++) begin
            @(negedge clk);
            check_slot(m);
            apply(m);
            if (m == RSLOT) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out_valid", m, 32'(out_valid), 0);
                chk("rst_out_neg", m, 32'(out_neg), 0);
                chk("rst_out_err", m, 32'(out_err), 0);
                chk("rst_digits", m, 32'(|out_digits), 0);
                chk("rst_err_count", m, 32'(err_count), 0);
                chk("rst_err_count_w4", m, 32'(err_count4), 0);
            end
            if (m == RSLOT + 1) begin
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
